// File: rtl/signed_divider_seq.sv
// Sequential two's-complement divider: 2N-bit dividend / N-bit divisor,
// restoring division on magnitudes, one quotient bit per clock.
module signed_divider_seq #(
   parameter int unsigned N = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [2*N-1:0]   dividend,
   input  logic [N-1:0]     divisor,
   output logic             busy,
   output logic             done,
   output logic [2*N-1:0]   quotient,
   output logic [N-1:0]     remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int unsigned DW = 2 * N;
   localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DIVIDE = 2'd1;
   localparam logic [1:0] S_SIGN   = 2'd2;
   localparam logic [1:0] S_ZERO   = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] dvd_q, dvd_d;      // dividend magnitude, quotient bits shift in at LSB
   logic [N-1:0]  dvs_q, dvs_d;
   logic [N-1:0]  rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          qneg_q, qneg_d;
   logic          rneg_q, rneg_d;
   logic          ovf_pend_q, ovf_pend_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [DW-1:0] quo_q, quo_d;
   logic [N-1:0]  remo_q, remo_d;
   logic          dbz_q, dbz_d;
   logic          ovf_q, ovf_d;

   logic [DW-1:0] dvd_abs;
   logic [N-1:0]  dvs_abs;
   logic [N:0]    pr;
   logic [N:0]    pr_sub;
   logic          pr_ge;

   // Magnitudes are unsigned, so the most negative values map to 2^(W-1)
   assign dvd_abs = dividend[DW-1] ? (~dividend + DW'(1)) : dividend;
   assign dvs_abs = divisor[N-1]   ? (~divisor + N'(1))   : divisor;

   assign pr     = {rem_q, dvd_q[DW-1]};
   assign pr_sub = pr - {1'b0, dvs_q};
   assign pr_ge  = (pr >= {1'b0, dvs_q});

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         dvd_q      <= '0;
         dvs_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         qneg_q     <= 1'b0;
         rneg_q     <= 1'b0;
         ovf_pend_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         quo_q      <= '0;
         remo_q     <= '0;
         dbz_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         rem_q      <= rem_d;
         cnt_q      <= cnt_d;
         qneg_q     <= qneg_d;
         rneg_q     <= rneg_d;
         ovf_pend_q <= ovf_pend_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         quo_q      <= quo_d;
         remo_q     <= remo_d;
         dbz_q      <= dbz_d;
         ovf_q      <= ovf_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      rem_d      = rem_q;
      cnt_d      = cnt_q;
      qneg_d     = qneg_q;
      rneg_d     = rneg_q;
      ovf_pend_d = ovf_pend_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      quo_d      = quo_q;
      remo_d     = remo_q;
      dbz_d      = dbz_q;
      ovf_d      = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               dvd_d      = dvd_abs;
               dvs_d      = dvs_abs;
               rem_d      = '0;
               cnt_d      = '0;
               qneg_d     = dividend[DW-1] ^ divisor[N-1];
               rneg_d     = dividend[DW-1];
               ovf_pend_d = (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);
               dbz_d      = 1'b0;
               ovf_d      = 1'b0;
               busy_d     = 1'b1;
               state_d    = (divisor == '0) ? S_ZERO : S_DIVIDE;
            end
         end
         S_DIVIDE: begin
            dvd_d = {dvd_q[DW-2:0], pr_ge};
            rem_d = pr_ge ? pr_sub[N-1:0] : pr[N-1:0];
            if (cnt_q == CW'(DW - 1)) begin
               cnt_d   = '0;
               state_d = S_SIGN;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_SIGN: begin
            quo_d   = qneg_q ? (~dvd_q + DW'(1)) : dvd_q;
            remo_d  = rneg_q ? (~rem_q + N'(1)) : rem_q;
            ovf_d   = ovf_pend_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         S_ZERO: begin
            quo_d   = '0;
            remo_d  = '0;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = remo_q;
   assign div_by_zero = dbz_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_signed_divider_seq.sv
// Scoreboard bench for signed_divider_seq (N=4): reference results come from
// native integer division, compared with latency when done pulses.
module tb_signed_divider_seq;

   localparam int N  = 4;
   localparam int DW = 2 * N;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] dividend = '0;
   logic [N-1:0]  divisor = '0;
   logic          busy, done, div_by_zero, overflow;
   logic [DW-1:0] quotient;
   logic [N-1:0]  remainder;

   typedef struct {
      logic [DW-1:0] q;
      logic [N-1:0]  r;
      logic          dbz;
      logic          ovf;
      int            due;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   signed_divider_seq #(.N(N)) dut (
      .clk(clk), .rstn(rstn), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model(input int a, input int b, input int due);
      exp_t e;
      e.due = due;
      e.dbz = 1'b0;
      e.ovf = 1'b0;
      if (b == 0) begin
         e.q = '0; e.r = '0; e.dbz = 1'b1;
      end else if (a == -(1 << (DW - 1)) && b == -1) begin
         e.q = DW'(a); e.r = '0; e.ovf = 1'b1;
      end else begin
         e.q = DW'(a / b);
         e.r = N'(a % b);
      end
      return e;
   endfunction

   // Drive one request at a negedge; expected result queued with its due cycle
   task automatic issue(input int a, input int b);
      int lat;
      lat = (b == 0) ? 1 : DW + 1;
      start    = 1'b1;
      dividend = DW'(a);
      divisor  = N'(b);
      sb.push_back(model(a, b, cyc + 1 + lat));
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = DW'($urandom);
      divisor  = N'($urandom);
      check("busy_after_accept", 32'(busy), 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && sb.size() != 0; i++) begin
         @(negedge clk);
         #2;
      end
      check("drain_timeout", 32'(sb.size()), 0);
   endtask

   task automatic run_op(input int a, input int b, input bit noise);
      @(negedge clk);
      issue(a, b);
      if (noise && b != 0) begin
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start    = 1'b1;
            dividend = DW'($urandom);
            divisor  = N'($urandom);
            @(negedge clk);
            start    = 1'b0;
         end
      end
      drain();
   endtask

   always @(negedge clk) begin
      if (done) begin
         check("sb_pending", 32'(sb.size() > 0), 1);
         check("busy_at_done", 32'(busy), 0);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("quotient", 32'(quotient), 32'(e.q));
            check("remainder", 32'(remainder), 32'(e.r));
            check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            check("overflow", 32'(overflow), 32'(e.ovf));
            check("latency", 32'(cyc), 32'(e.due));
         end
      end
   end

   initial begin
      exp_t held;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_q", 32'(quotient), 0);
      check("rst_r", 32'(remainder), 0);
      check("rst_flags", 32'({div_by_zero, overflow}), 0);
      rstn = 1'b1;

      run_op(-56, 7, 1'b0);
      run_op(45, -4, 1'b0);
      run_op(-45, 4, 1'b0);
      run_op(-128, -8, 1'b0);
      run_op(127, -8, 1'b0);
      run_op(100, 0, 1'b0);
      run_op(-128, -1, 1'b0);
      run_op(-128, 1, 1'b0);
      run_op(0, -3, 1'b0);
      run_op(77, 5, 1'b1);
      run_op(-99, -6, 1'b1);

      // Back-to-back: start held in the done cycle, prior results held meanwhile
      @(negedge clk);
      issue(-77, 3);
      held = model(-77, 3, 0);
      for (int i = 0; i < 40; i++) begin
         if (done) break;
         @(negedge clk);
      end
      check("b2b_done_seen", 32'(done), 1);
      issue(113, -7);
      check("b2b_held_q", 32'(quotient), 32'(held.q));
      check("b2b_held_r", 32'(remainder), 32'(held.r));
      drain();

      // Reset mid-DIVIDE: abort without a done pulse
      @(negedge clk);
      start = 1'b1; dividend = DW'(100); divisor = N'(7);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 0);
      check("abort_done", 32'(done), 0);
      check("abort_q", 32'(quotient), 0);
      check("abort_r", 32'(remainder), 0);
      @(negedge clk);
      rstn = 1'b1;
      repeat (15) @(negedge clk);
      run_op(-56, 7, 1'b0);

      for (int i = 0; i < 24; i++) begin
         int a, b;
         a = int'($urandom_range(0, 255)) - 128;
         b = int'($urandom_range(0, 15)) - 8;
         run_op(a, b, i[0]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
